// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle 16-bit datapath: FETCH/DECODE/EXEC/MEM/WB with internal regfile and dmem
module mc_datapath #(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 6,
   parameter int DMEM_AW  = 3
) (
   input  logic                clk,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [15:0]         imem_data,
   input  logic                imem_valid,
   input  logic                PCSrc,
   input  logic                RegSrc,
   input  logic                RegEn,
   input  logic                ALUSrc,
   input  logic [3:0]          ALUOp,
   input  logic                DmemWr,
   input  logic                WrSrc,
   output logic [4:0]          Inst,
   output logic                IsZero,
   output logic [2:0]          state,
   output logic                retire
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [15:0]          ir_q;
   logic [WIDTH-1:0]     a_q, b_q, alu_q, mdr_q;
   logic                 zero_q;
   logic [WIDTH-1:0]     rf_q   [8];
   logic [WIDTH-1:0]     dmem_q [2**DMEM_AW];

   logic [2:0]           rd, ra, rb, rb_sel;
   logic [WIDTH-1:0]     imm_sext, bsel, alu_d, wb_data, rd_a, rd_b;
   logic [3:0]           shamt;
   logic [DMEM_AW-1:0]   dm_addr;
   logic [PC_WIDTH-1:0]  br_off;

   assign rd       = ir_q[10:8];
   assign ra       = ir_q[7:5];
   assign rb       = ir_q[4:2];
   assign imm_sext = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};
   // Branch offset is imm*2; the top bit of the 4 low imm bits plus sign fills PC_WIDTH (needs PC_WIDTH >= 6).
   assign br_off   = {{(PC_WIDTH-5){ir_q[4]}}, ir_q[3:0], 1'b0};
   assign rb_sel   = RegSrc ? rb : rd;
   // r0 is hard-wired to zero on the read side as well as never being written.
   assign rd_a     = (ra == 3'd0) ? '0 : rf_q[ra];
   assign rd_b     = (rb_sel == 3'd0) ? '0 : rf_q[rb_sel];
   assign bsel     = ALUSrc ? imm_sext : b_q;
   assign shamt    = bsel[3:0];
   assign dm_addr  = alu_q[DMEM_AW-1:0];
   assign wb_data  = WrSrc ? alu_q : mdr_q;

   assign imem_addr = pc_q;
   assign Inst      = ir_q[15:11];
   assign IsZero    = zero_q;
   assign state     = state_q;
   assign retire    = (state_q == WB);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next-state: FETCH waits for a valid instruction, the rest advance every cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (imem_valid) state_d = DECODE;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = MEM;
         MEM:     state_d = WB;
         WB:      state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // ALU: all arithmetic wraps at WIDTH bits; shifts use only the low 4 bits of operand B.
   always_comb begin
      alu_d = a_q;
      case (ALUOp)
         4'd0:    alu_d = a_q + bsel;
         4'd1:    alu_d = a_q - bsel;
         4'd2:    alu_d = a_q & bsel;
         4'd3:    alu_d = a_q | bsel;
         4'd4:    alu_d = a_q ^ bsel;
         4'd5:    alu_d = ~(a_q | bsel);
         4'd6:    alu_d = a_q << shamt;
         4'd7:    alu_d = a_q >> shamt;
         4'd8:    alu_d = $unsigned($signed(a_q) >>> shamt);
         4'd9:    alu_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(bsel))};
         4'd10:   alu_d = {{(WIDTH-1){1'b0}}, (a_q < bsel)};
         4'd11:   alu_d = bsel;
         default: alu_d = a_q;
      endcase
   end

   // Next PC, only consumed in WB.
   always_comb begin
      pc_d = PCSrc ? (pc_q + br_off) : (pc_q + PC_WIDTH'(2));
   end

   // Holding registers, each loaded only in the state that owns it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         alu_q  <= '0;
         mdr_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH:   if (imem_valid) ir_q <= imem_data;
            DECODE: begin
               a_q <= rd_a;
               b_q <= rd_b;
            end
            EXEC: begin
               alu_q  <= alu_d;
               zero_q <= (alu_d == '0);
            end
            MEM:     mdr_q <= dmem_q[dm_addr];
            default: ;
         endcase
      end
   end

   // Program counter advances only at the WB->FETCH edge.
   always_ff @(posedge clk) begin
      if (reset)               pc_q <= '0;
      else if (state_q == WB)  pc_q <= pc_d;
   end

   // Register file write-back; r0 is never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (state_q == WB && RegEn && rd != 3'd0) begin
         rf_q[rd] <= wb_data;
      end
   end

   // Data memory store in MEM; MDR above captures the pre-write contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**DMEM_AW; i++) dmem_q[i] <= '0;
      end else if (state_q == MEM && DmemWr) begin
         dmem_q[dm_addr] <= b_q;
      end
   end

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - directed self-checking bench for mc_datapath
module tb_mc_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [15:0] imem_data;
   logic        imem_valid;
   logic        PCSrc, RegSrc, RegEn, ALUSrc, DmemWr, WrSrc;
   logic [3:0]  ALUOp;
   logic [4:0]  Inst;
   logic        IsZero;
   logic [2:0]  state;
   logic        retire;

   int errors = 0;
   int checks = 0;
   int exp_pc = 0;
   logic [4:0] prev_inst = 5'd0;

   mc_datapath #(.WIDTH(16), .PC_WIDTH(6), .DMEM_AW(3)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_valid(imem_valid), .PCSrc(PCSrc), .RegSrc(RegSrc), .RegEn(RegEn),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .DmemWr(DmemWr), .WrSrc(WrSrc),
      .Inst(Inst), .IsZero(IsZero), .state(state), .retire(retire)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [4:0] im);
      return {op, rd, ra, im};
   endfunction

   task automatic do_reset();
      reset = 1'b1; imem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_pc = 0; prev_inst = 5'd0;
   endtask

   // Runs one instruction from FETCH back to FETCH, checking state/retire/Inst/addr each cycle.
   task automatic do_instr(input logic [15:0] ins, input logic rs, input logic as,
                           input logic [3:0] op, input logic dw, input logic ws,
                           input logic re, input logic ps, input int stall, input bit rst_wb);
      int pc0, es, o;
      pc0 = exp_pc;
      imem_data = ins; RegSrc = rs; ALUSrc = as; ALUOp = op;
      DmemWr = dw; WrSrc = ws; RegEn = re; PCSrc = ps;
      imem_valid = (stall == 0);
      chk("fetch_state", 32'(state), 0);
      chk("fetch_inst", 32'(Inst), 32'(prev_inst));
      for (int c = 2; c <= 5 + stall; c++) begin
         @(posedge clk); #1;
         imem_valid = (c > stall);
         es = (c <= stall + 1) ? 0 : c - stall - 1;
         chk("state", 32'(state), 32'(es));
         chk("retire", 32'(retire), 32'(es == 4));
         chk("addr_hold", 32'(imem_addr), 32'(pc0));
         chk("inst", 32'(Inst), (es == 0) ? 32'(prev_inst) : 32'(ins[15:11]));
      end
      if (rst_wb) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         exp_pc = 0; prev_inst = 5'd0;
         chk("rst_wb_inst", 32'(Inst), 0);
      end else begin
         @(posedge clk); #1;
         o = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
         exp_pc = ps ? ((exp_pc + 2 * o) & 63) : ((exp_pc + 2) & 63);
         prev_inst = ins[15:11];
      end
      imem_valid = 1'b0;
      chk("next_state", 32'(state), 0);
      chk("next_retire", 32'(retire), 0);
      chk("next_addr", 32'(imem_addr), 32'(exp_pc));
   endtask

   // IsZero after SUB of R[r] with sext(v) tells whether R[r] == sext(v).
   task automatic probe(input string tag, input logic [2:0] r, input logic [4:0] v,
                        input logic exp_zero);
      do_instr(enc(5'h10, 3'd0, r, v), 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk(tag, 32'(IsZero), 32'(exp_zero));
   endtask

   logic [3:0] alu_op_t [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd1};
   logic [4:0] alu_im_t [12] = '{5'd2, 5'd0, 5'd5, 5'h1F, 5'd15, 5'd3, 5'd2, 5'h1F, 5'h1F, 5'd0, 5'd0, 5'd5};
   logic       alu_z_t  [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      reset = 1'b1; imem_valid = 1'b0; imem_data = '0;
      PCSrc = 0; RegSrc = 0; RegEn = 0; ALUSrc = 0; ALUOp = '0; DmemWr = 0; WrSrc = 0;
      do_reset();
      chk("rst_state", 32'(state), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_retire", 32'(retire), 0);
      chk("rst_iszero", 32'(IsZero), 0);
      chk("rst_inst", 32'(Inst), 0);

      // All registers read zero after reset.
      for (int r = 0; r < 8; r++) probe($sformatf("rst_r%0d", r), 3'(r), 5'd0, 1'b1);

      // R1 <- R0 + 5; R2 <- R1 - R1.
      do_instr(enc(5'h01, 3'd1, 3'd0, 5'd5), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      chk("addi_iszero", 32'(IsZero), 0);
      do_instr(enc(5'h02, 3'd2, 3'd1, {3'd1, 2'b00}), 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      chk("sub_iszero", 32'(IsZero), 1);
      probe("r1_is_5", 3'd1, 5'd5, 1'b1);
      probe("r2_is_0", 3'd2, 5'd0, 1'b1);

      // ALU function table with A = R1 = 5 and an immediate operand.
      for (int i = 0; i < 12; i++) begin
         do_instr(enc(5'h03, 3'd0, 3'd1, alu_im_t[i]), 1'b0, 1'b1, alu_op_t[i], 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
         chk($sformatf("alu_op%0d", alu_op_t[i]), 32'(IsZero), 32'(alu_z_t[i]));
      end

      // Store R1 to dmem[3], load it into R3, then try writing r0.
      do_instr(enc(5'h04, 3'd1, 3'd0, 5'd3), 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      do_instr(enc(5'h05, 3'd3, 3'd0, 5'd3), 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      probe("r3_is_5", 3'd3, 5'd5, 1'b1);
      probe("r3_not_0", 3'd3, 5'd0, 1'b0);
      do_instr(enc(5'h06, 3'd0, 3'd1, 5'd0), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      probe("r0_stays_0", 3'd0, 5'd0, 1'b1);

      // Branch wrap-around from PC 0 backward, then sequential wrap forward.
      do_reset();
      do_instr(enc(5'h18, 3'd0, 3'd0, 5'h1E), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      chk("pc_back_wrap", 32'(imem_addr), 60);
      do_instr(enc(5'h18, 3'd0, 3'd0, 5'h1E), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("pc_62", 32'(imem_addr), 62);
      do_instr(enc(5'h18, 3'd0, 3'd0, 5'h1E), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("pc_fwd_wrap", 32'(imem_addr), 0);
      do_instr(enc(5'h18, 3'd0, 3'd0, 5'h0F), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      chk("pc_fwd_branch", 32'(imem_addr), 30);

      // Three stall cycles in FETCH stretch the instruction to 8 cycles.
      do_instr(enc(5'h1F, 3'd0, 3'd0, 5'd0), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0);
      chk("stall_pc", 32'(imem_addr), 32);

      // Reset in WB suppresses register and PC writes.
      do_instr(enc(5'h07, 3'd4, 3'd0, 5'd7), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1);
      chk("rst_wb_pc", 32'(imem_addr), 0);
      probe("rst_wb_r4", 3'd4, 5'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
